// File: rtl/branch_resolve_if.sv
// Bundle between fetch/execute and the branch resolve unit: prediction
// records in, resolved outcomes in, predictor update and redirect out.
interface branch_resolve_if #(
  parameter int BHR_W = 4,
  parameter int IDX_W = 8,
  parameter int CNT_W = 4
);
  logic              pred_valid;
  logic              pred_ready;
  logic [31:0]       pred_pc;
  logic              pred_taken;
  logic [31:0]       pred_target;
  logic [1:0]        pred_type;
  logic [BHR_W-1:0]  pred_bhr;
  logic [IDX_W-1:0]  pred_pht_idx;
  logic [IDX_W-1:0]  pred_bht_idx;

  logic              res_valid;
  logic              res_taken;
  logic [31:0]       res_target;

  logic              upd_en;
  logic [31:0]       upd_pc;
  logic              upd_taken;
  logic [31:0]       upd_target;
  logic [1:0]        upd_type;
  logic [BHR_W-1:0]  upd_bhr;
  logic [IDX_W-1:0]  upd_pht_idx;
  logic [IDX_W-1:0]  upd_bht_idx;

  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              res_err;
  logic [CNT_W-1:0]  count;
  logic [15:0]       stat_mispred;

  // Fetch/execute side
  modport master (
    output pred_valid, pred_pc, pred_taken, pred_target, pred_type,
           pred_bhr, pred_pht_idx, pred_bht_idx,
           res_valid, res_taken, res_target,
    input  pred_ready, upd_en, upd_pc, upd_taken, upd_target, upd_type,
           upd_bhr, upd_pht_idx, upd_bht_idx,
           redirect, redirect_pc, res_err, count, stat_mispred
  );

  // Resolve unit side
  modport slave (
    input  pred_valid, pred_pc, pred_taken, pred_target, pred_type,
           pred_bhr, pred_pht_idx, pred_bht_idx,
           res_valid, res_taken, res_target,
    output pred_ready, upd_en, upd_pc, upd_taken, upd_target, upd_type,
           upd_bhr, upd_pht_idx, upd_bht_idx,
           redirect, redirect_pc, res_err, count, stat_mispred
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: in-order FIFO of prediction records, checked against
// execute outcomes; drives predictor update and mispredict redirect/flush.
module branch_resolve_unit #(
  parameter int DEPTH = 8,
  parameter int BHR_W = 4,
  parameter int IDX_W = 8,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  branch_resolve_if.slave        bus
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0]      pc;
    logic             taken;
    logic [31:0]      target;
    logic [1:0]       btype;
    logic [BHR_W-1:0] bhr;
    logic [IDX_W-1:0] pht_idx;
    logic [IDX_W-1:0] bht_idx;
  } rec_t;

  rec_t             mem [DEPTH];
  rec_t             head;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count_q;
  logic             full, empty, enq, resolve, mispred, flush;

  logic             upd_en_q, upd_taken_q, redirect_q, res_err_q;
  logic [31:0]      upd_pc_q, upd_target_q, redirect_pc_q;
  logic [1:0]       upd_type_q;
  logic [BHR_W-1:0] upd_bhr_q;
  logic [IDX_W-1:0] upd_pht_q, upd_bht_q;
  logic [15:0]      stat_q;
  logic [31:0]      actual_next;

  // Handshake, head lookup and mispredict detection
  always_comb begin
    full        = (count_q == CNT_W'(DEPTH));
    empty       = (count_q == '0);
    bus.pred_ready = !full && !reset;
    enq         = bus.pred_valid && bus.pred_ready;
    resolve     = bus.res_valid && !empty;
    head        = mem[rd_ptr];
    mispred     = (head.taken != bus.res_taken) ||
                  (bus.res_taken && (head.target != bus.res_target));
    flush       = resolve && mispred;
    actual_next = bus.res_taken ? bus.res_target : head.pc + 32'd4;
  end

  // Record storage; wrong-path records arriving with a flush are not written
  always_ff @(posedge clk) begin
    if (enq && !flush) begin
      mem[wr_ptr] <= '{pc: bus.pred_pc, taken: bus.pred_taken,
                       target: bus.pred_target, btype: bus.pred_type,
                       bhr: bus.pred_bhr, pht_idx: bus.pred_pht_idx,
                       bht_idx: bus.pred_bht_idx};
    end
  end

  // Pointers, occupancy and registered update/redirect outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count_q       <= '0;
      upd_en_q      <= 1'b0;
      upd_pc_q      <= '0;
      upd_taken_q   <= 1'b0;
      upd_target_q  <= '0;
      upd_type_q    <= '0;
      upd_bhr_q     <= '0;
      upd_pht_q     <= '0;
      upd_bht_q     <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      res_err_q     <= 1'b0;
      stat_q        <= '0;
    end else begin
      upd_en_q   <= resolve;
      redirect_q <= flush;
      res_err_q  <= bus.res_valid && empty;
      if (resolve) begin
        upd_pc_q     <= head.pc;
        upd_taken_q  <= bus.res_taken;
        upd_target_q <= actual_next;
        upd_type_q   <= head.btype;
        upd_bhr_q    <= head.bhr;
        upd_pht_q    <= head.pht_idx;
        upd_bht_q    <= head.bht_idx;
      end
      if (flush) begin
        redirect_pc_q <= actual_next;
        if (stat_q != '1) stat_q <= stat_q + 16'd1;
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (enq)     wr_ptr <= wr_ptr + PTR_W'(1);
        if (resolve) rd_ptr <= rd_ptr + PTR_W'(1);
        if (enq && !resolve)      count_q <= count_q + CNT_W'(1);
        else if (!enq && resolve) count_q <= count_q - CNT_W'(1);
      end
    end
  end

  assign bus.upd_en       = upd_en_q;
  assign bus.upd_pc       = upd_pc_q;
  assign bus.upd_taken    = upd_taken_q;
  assign bus.upd_target   = upd_target_q;
  assign bus.upd_type     = upd_type_q;
  assign bus.upd_bhr      = upd_bhr_q;
  assign bus.upd_pht_idx  = upd_pht_q;
  assign bus.upd_bht_idx  = upd_bht_q;
  assign bus.redirect     = redirect_q;
  assign bus.redirect_pc  = redirect_pc_q;
  assign bus.res_err      = res_err_q;
  assign bus.count        = count_q;
  assign bus.stat_mispred = stat_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with hand-computed expectations.
module tb_branch_resolve_unit;
  logic clk = 1'b0;
  logic reset;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  branch_resolve_if #(.BHR_W(4), .IDX_W(8), .CNT_W(4)) bus ();

  branch_resolve_unit #(.DEPTH(8), .BHR_W(4), .IDX_W(8), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pred(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    bus.pred_valid   = 1'b1;
    bus.pred_pc      = pc;
    bus.pred_taken   = taken;
    bus.pred_target  = tgt;
    bus.pred_type    = pc[3:2];
    bus.pred_bhr     = pc[7:4];
    bus.pred_pht_idx = pc[9:2];
    bus.pred_bht_idx = pc[11:4];
  endtask

  task automatic enq(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    set_pred(pc, taken, tgt);
    step();
    bus.pred_valid = 1'b0;
  endtask

  task automatic resolve(input logic taken, input logic [31:0] tgt);
    bus.res_valid  = 1'b1;
    bus.res_taken  = taken;
    bus.res_target = tgt;
    step();
    bus.res_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] q_pc [$];
    int unsigned nres;
    logic [31:0] p;

    reset = 1'b1;
    bus.pred_valid = 1'b0; bus.res_valid = 1'b0; bus.res_taken = 1'b0;
    bus.res_target = '0;
    set_pred('0, 1'b0, '0); bus.pred_valid = 1'b0;
    step(); step();
    check("ready_in_reset", 32'(bus.pred_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_ready", 32'(bus.pred_ready), 32'd1);
    check("rst_upd_en", 32'(bus.upd_en), 32'd0);
    check("rst_redirect", 32'(bus.redirect), 32'd0);
    check("rst_res_err", 32'(bus.res_err), 32'd0);
    check("rst_stat", 32'(bus.stat_mispred), 32'd0);

    // Correct taken prediction
    enq(32'h100, 1'b1, 32'h200);
    check("t2_count1", 32'(bus.count), 32'd1);
    resolve(1'b1, 32'h200);
    check("t2_upd_en", 32'(bus.upd_en), 32'd1);
    check("t2_upd_pc", bus.upd_pc, 32'h100);
    check("t2_upd_target", bus.upd_target, 32'h200);
    check("t2_upd_taken", 32'(bus.upd_taken), 32'd1);
    check("t2_upd_type", 32'(bus.upd_type), 32'd0);
    check("t2_upd_pht", 32'(bus.upd_pht_idx), 32'h40);
    check("t2_redirect", 32'(bus.redirect), 32'd0);
    check("t2_count", 32'(bus.count), 32'd0);
    step();
    check("t2_upd_en_pulse", 32'(bus.upd_en), 32'd0);
    check("t2_upd_pc_hold", bus.upd_pc, 32'h100);

    // Direction mispredict flushes younger records
    enq(32'h100, 1'b0, 32'h0);
    enq(32'h104, 1'b0, 32'h0);
    enq(32'h108, 1'b0, 32'h0);
    check("t3_count3", 32'(bus.count), 32'd3);
    resolve(1'b1, 32'h400);
    check("t3_redirect", 32'(bus.redirect), 32'd1);
    check("t3_redirect_pc", bus.redirect_pc, 32'h400);
    check("t3_count", 32'(bus.count), 32'd0);
    check("t3_stat", 32'(bus.stat_mispred), 32'd1);
    check("t3_upd_en", 32'(bus.upd_en), 32'd1);
    step();
    check("t3_redirect_pulse", 32'(bus.redirect), 32'd0);
    check("t3_rpc_hold", bus.redirect_pc, 32'h400);

    // Predicted taken, actually not taken -> fall-through pc+4
    enq(32'h500, 1'b1, 32'h600);
    resolve(1'b0, 32'h600);
    check("nt_redirect", 32'(bus.redirect), 32'd1);
    check("nt_redirect_pc", bus.redirect_pc, 32'h504);
    check("nt_upd_target", bus.upd_target, 32'h504);
    check("nt_stat", 32'(bus.stat_mispred), 32'd2);

    // Fill to DEPTH, overflow attempt, then drain
    for (int i = 0; i < 8; i++) enq(32'h1000 + 32'(4 * i), 1'b0, 32'h0);
    check("t4_count_full", 32'(bus.count), 32'd8);
    check("t4_ready_full", 32'(bus.pred_ready), 32'd0);
    enq(32'hDEAD0, 1'b0, 32'h0);
    check("t4_count_9th", 32'(bus.count), 32'd8);
    resolve(1'b0, 32'h0);
    check("t4_count7", 32'(bus.count), 32'd7);
    check("t4_ready", 32'(bus.pred_ready), 32'd1);
    check("t4_upd_pc", bus.upd_pc, 32'h1000);
    check("t4_upd_target", bus.upd_target, 32'h1004);
    check("t4_redirect", 32'(bus.redirect), 32'd0);
    for (int i = 1; i < 8; i++) begin
      resolve(1'b0, 32'h0);
      check("t4_drain_pc", bus.upd_pc, 32'h1000 + 32'(4 * i));
    end
    check("t4_empty", 32'(bus.count), 32'd0);
    check("t4_stat", 32'(bus.stat_mispred), 32'd2);

    // Resolve while empty
    resolve(1'b1, 32'h0);
    check("t5_res_err", 32'(bus.res_err), 32'd1);
    check("t5_upd_en", 32'(bus.upd_en), 32'd0);
    step();
    check("t5_res_err_pulse", 32'(bus.res_err), 32'd0);

    // Target mismatch with a same-cycle (wrong-path) enqueue
    enq(32'hA00, 1'b1, 32'h200);
    set_pred(32'hB00, 1'b0, 32'h0);
    resolve(1'b1, 32'h300);
    bus.pred_valid = 1'b0;
    check("t5_redirect", 32'(bus.redirect), 32'd1);
    check("t5_redirect_pc", bus.redirect_pc, 32'h300);
    check("t5_count", 32'(bus.count), 32'd0);
    check("t5_stat", 32'(bus.stat_mispred), 32'd3);
    resolve(1'b0, 32'h0);
    check("t5_dropped_rec", 32'(bus.res_err), 32'd1);

    // Simultaneous enqueue + correct resolve keeps count
    enq(32'hC00, 1'b0, 32'h0);
    set_pred(32'hC04, 1'b0, 32'h0);
    resolve(1'b0, 32'h0);
    bus.pred_valid = 1'b0;
    check("sim_count", 32'(bus.count), 32'd1);
    check("sim_upd_pc", bus.upd_pc, 32'hC00);
    resolve(1'b0, 32'h0);
    check("sim_upd_pc2", bus.upd_pc, 32'hC04);
    check("sim_count0", 32'(bus.count), 32'd0);

    // Stream 20 records with overlap; pointers wrap
    nres = 0;
    for (int k = 0; k < 23; k++) begin
      if (k < 20) begin
        p = 32'h2000 + 32'(16 * k);
        set_pred(p, 1'(k & 1), 32'h3000 + 32'(16 * k));
        q_pc.push_back(p);
      end else bus.pred_valid = 1'b0;
      bus.res_valid  = (k >= 3);
      bus.res_taken  = 1'(nres & 1);
      bus.res_target = 32'h3000 + 32'(16 * nres);
      step();
      if (k >= 3) begin
        check("s_upd_en", 32'(bus.upd_en), 32'd1);
        check("s_upd_pc", bus.upd_pc, q_pc.pop_front());
        check("s_redirect", 32'(bus.redirect), 32'd0);
        nres++;
      end
    end
    bus.pred_valid = 1'b0;
    bus.res_valid  = 1'b0;
    check("s_count", 32'(bus.count), 32'd0);
    check("s_stat", 32'(bus.stat_mispred), 32'd3);

    // Reset mid-operation suppresses pending pulses
    enq(32'h4000, 1'b0, 32'h0);
    enq(32'h4004, 1'b0, 32'h0);
    bus.res_valid = 1'b1; bus.res_taken = 1'b1; bus.res_target = 32'h9000;
    reset = 1'b1;
    step();
    bus.res_valid = 1'b0;
    check("mr_count", 32'(bus.count), 32'd0);
    check("mr_upd_en", 32'(bus.upd_en), 32'd0);
    check("mr_redirect", 32'(bus.redirect), 32'd0);
    check("mr_stat", 32'(bus.stat_mispred), 32'd0);
    reset = 1'b0;
    step();
    check("mr_ready", 32'(bus.pred_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
